// File: rtl/modexp_pkg.sv
// Shared definitions for the parametrised modular exponentiator:
// FSM state encoding, modmul latency and parameter range checks.
package modexp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_SCAN,
        ST_SQR,
        ST_MUL,
        ST_NEXT,
        ST_FIN,
        ST_DONE
    } state_t;

    localparam int unsigned MIN_WIDTH     = 4;
    localparam int unsigned MIN_EXP_WIDTH = 1;

    // Cycles from a modmul start pulse to its done pulse.
    function automatic int unsigned modmul_latency(input int unsigned width);
        return width + 1;
    endfunction

    function automatic bit widths_ok(input int unsigned width, input int unsigned exp_width);
        return (width >= MIN_WIDTH) && (exp_width >= MIN_EXP_WIDTH);
    endfunction

endpackage

// File: rtl/modmul_serial.sv
// Bit-serial interleaved modular multiplier: P = A*B mod N, MSB of B first,
// one bit per cycle; done pulses WIDTH+1 cycles after start.
module modmul_serial
    import modexp_pkg::*;
#(
    parameter int unsigned WIDTH = 4096
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [WIDTH-1:0] i_n,
    output logic             o_done,
    output logic [WIDTH-1:0] o_p
);

    localparam int unsigned CW = $clog2(WIDTH);

    logic [WIDTH-1:0] r_p;
    logic [CW-1:0]    r_j;
    logic             r_run;
    logic             r_done;

    logic [WIDTH+1:0] w_sum;
    logic [WIDTH+1:0] w_n;
    logic [WIDTH+1:0] w_s1;
    logic [WIDTH-1:0] w_red;

    // 2P + A < 3N fits in WIDTH+2 bits, so two subtractions always reduce below N.
    // Operands are read live and must stay stable while a multiply runs.
    always_comb begin
        w_n   = {2'b00, i_n};
        w_sum = {1'b0, r_p, 1'b0} + (i_b[r_j] ? {2'b00, i_a} : '0);
        w_s1  = (w_sum >= w_n) ? (w_sum - w_n) : w_sum;
        w_red = (w_s1 >= w_n) ? WIDTH'(w_s1 - w_n) : w_s1[WIDTH-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_p    <= '0;
            r_j    <= '0;
            r_run  <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_start) begin
                r_p   <= '0;
                r_j   <= CW'(WIDTH - 1);
                r_run <= 1'b1;
            end else if (r_run) begin
                r_p <= w_red;
                if (r_j == '0) begin
                    r_run  <= 1'b0;
                    r_done <= 1'b1;
                end else begin
                    r_j <= r_j - 1'b1;
                end
            end
        end
    end

    assign o_done = r_done;
    assign o_p    = r_p;

endmodule

// File: rtl/modexp_param.sv
// Parametrised cypher = message^exponent mod modulus, left-to-right square-and-multiply.
// Define MODEXP_CONST_TIME_EN for fixed latency (no zero skip, multiply on every bit).
module modexp_param
    import modexp_pkg::*;
#(
    parameter int unsigned WIDTH     = 4096,
    parameter int unsigned EXP_WIDTH = WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 go,
    input  logic [WIDTH-1:0]     message,
    input  logic [EXP_WIDTH-1:0] exponent,
    input  logic [WIDTH-1:0]     modulus,
    output logic [WIDTH-1:0]     cypher,
    output logic                 done,
    output logic                 busy,
    output logic                 error
);

    localparam int unsigned IW = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;

    if (!widths_ok(WIDTH, EXP_WIDTH)) begin : g_bad_width
        $error("modexp_param: WIDTH must be >= 4 and EXP_WIDTH >= 1");
    end

    state_t               r_state;
    state_t               w_next;
    logic [WIDTH-1:0]     r_msg;
    logic [EXP_WIDTH-1:0] r_exp;
    logic [WIDTH-1:0]     r_mod;
    logic [WIDTH-1:0]     r_r;
    logic [IW-1:0]        r_idx;
    logic [WIDTH-1:0]     r_cypher;
    logic                 r_done;
    logic                 r_busy;
    logic                 r_error;
    logic                 r_mm_busy;

    logic                 w_bad;
    logic                 w_mm_start;
    logic [WIDTH-1:0]     w_mm_b;
    logic                 w_mm_done;
    logic [WIDTH-1:0]     w_mm_p;

    modmul_serial #(.WIDTH(WIDTH)) u_modmul (
        .clk     (clk),
        .reset   (reset),
        .i_start (w_mm_start),
        .i_a     (r_r),
        .i_b     (w_mm_b),
        .i_n     (r_mod),
        .o_done  (w_mm_done),
        .o_p     (w_mm_p)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        w_bad      = (r_mod < WIDTH'(2)) || (r_msg >= r_mod);
        w_mm_start = ((r_state == ST_SQR) || (r_state == ST_MUL)) && !r_mm_busy;
        w_mm_b     = (r_state == ST_SQR) ? r_r : r_msg;
        case (r_state)
            ST_IDLE:  if (go) w_next = ST_CHECK;
            ST_CHECK: begin
                if (w_bad) begin
                    w_next = ST_DONE;
                end else begin
`ifdef MODEXP_CONST_TIME_EN
                    w_next = ST_SQR;
`else
                    w_next = ST_SCAN;
`endif
                end
            end
            ST_SCAN: begin
                if (r_exp == '0)        w_next = ST_FIN;
                else if (r_exp[r_idx])  w_next = ST_SQR;
            end
            ST_SQR: begin
                if (w_mm_done) begin
`ifdef MODEXP_CONST_TIME_EN
                    w_next = ST_MUL;
`else
                    w_next = r_exp[r_idx] ? ST_MUL : ST_NEXT;
`endif
                end
            end
            ST_MUL:   if (w_mm_done) w_next = ST_NEXT;
            ST_NEXT:  w_next = (r_idx == '0) ? ST_FIN : ST_SQR;
            ST_FIN:   w_next = ST_DONE;
            ST_DONE:  if (!go) w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_msg     <= '0;
            r_exp     <= '0;
            r_mod     <= '0;
            r_r       <= '0;
            r_idx     <= '0;
            r_cypher  <= '0;
            r_done    <= 1'b0;
            r_busy    <= 1'b0;
            r_error   <= 1'b0;
            r_mm_busy <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (go) begin
                        r_msg <= message;
                        r_exp <= exponent;
                        r_mod <= modulus;
                    end
                end
                ST_CHECK: begin
                    r_r   <= WIDTH'(1);
                    r_idx <= IW'(EXP_WIDTH - 1);
                    if (w_bad) begin
                        r_error  <= 1'b1;
                        r_cypher <= '0;
                    end
                end
                ST_SCAN: if (!r_exp[r_idx] && (r_idx != '0)) r_idx <= r_idx - 1'b1;
                ST_SQR:  if (w_mm_done) r_r <= w_mm_p;
                // In constant-time mode the product of a zero bit is computed but dropped.
                ST_MUL:  if (w_mm_done && r_exp[r_idx]) r_r <= w_mm_p;
                ST_NEXT: if (r_idx != '0) r_idx <= r_idx - 1'b1;
                ST_FIN:  r_cypher <= r_r;
                ST_DONE: begin
                    if (!go) begin
                        r_cypher <= '0;
                        r_error  <= 1'b0;
                    end
                end
                default: ;
            endcase

            r_done <= (w_next == ST_DONE);
            r_busy <= (w_next != ST_DONE) && (w_next != ST_IDLE);

            if (w_mm_start)     r_mm_busy <= 1'b1;
            else if (w_mm_done) r_mm_busy <= 1'b0;
        end
    end

    assign cypher = r_cypher;
    assign done   = r_done;
    assign busy   = r_busy;
    assign error  = r_error;

endmodule
